score_topk_select: RTL

// Downstream stage of the 8-way diffusion top: consumes one bank of the accumulated score-sum memory.
// - Starts when the diffusion top has finished_all.
// - Scans the bank sequentially.
// - Keeps a sorted on-chip list of the TOPK highest scores with their node IDs.
// - Streams the list out over valid/ready, highest score first.
// One instance per PARALLEL bank. The host merges the bank results.

---
 rtl/score_topk_select_if.sv | 40 ++++
 rtl/score_topk_select.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_topk_select_if.sv
// Result stream bundle for score_topk_select.
// Carries one (node ID, score) beat per handshake, highest score first.
//
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid is raised, the producer holds
// out_valid, out_node, out_score and out_last stable until that edge.
// out_ready may change freely and does not depend on out_valid.
//
// Signals:
//   out_valid  producer -> consumer  beat valid
//   out_ready  consumer -> producer  beat accepted when out_valid is also high
//   out_node   producer -> consumer  node ID (score-memory address) of the beat
//   out_score  producer -> consumer  score of the beat
//   out_last   producer -> consumer  marks the final beat of a result list
interface score_topk_select_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13
);
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_node;
  logic [DATA_WIDTH-1:0] out_score;
  logic                  out_last;

  modport master (
    output out_valid,
    input  out_ready,
    output out_node,
    output out_score,
    output out_last
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_node,
    input  out_score,
    input  out_last
  );
endinterface

// File: rtl/score_topk_select.sv
// Top-K selector for one bank of the accumulated score-sum memory.
// After start, it reads addresses 0..node_num-1, keeps a sorted list of the
// TOPK largest unsigned scores with their node IDs, then streams the list
// out highest score first over the res interface.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse, accepted only when idle
//   mem_addr     score-memory read address (holds when mem_rd_en is low)
//   mem_rd_en    read strobe; data returns on mem_data_in one cycle later
//   mem_data_in  read data
//   busy         high from the accepted start until the final beat is taken
//   done         one-cycle pulse after the final beat is accepted
//   dbg_state    current FSM state (IDLE=0, SCAN=1, FLUSH=2, EMIT=3)
//   res          result stream (out_valid/out_ready/out_node/out_score/out_last)
module score_topk_select #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int node_num   = 40,
  parameter int TOPK       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state,
  score_topk_select_if.master   res
);

  // Only the first NOUT slots can ever be valid when the bank is smaller
  // than the list depth.
  localparam int NOUT = (TOPK < node_num) ? TOPK : node_num;
  localparam int EW   = (TOPK > 1) ? $clog2(TOPK) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(node_num - 1);
  localparam logic [EW-1:0]         LAST_E    = EW'(NOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    EMIT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [EW-1:0]         e_q;
  logic                  busy_q;
  logic                  done_q;

  // Read pipeline: marks that mem_data_in carries the sample for rd_node_q.
  logic                  rd_pend_q;
  logic [ADDR_WIDTH-1:0] rd_node_q;

  // Registered result beat.
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [ADDR_WIDTH-1:0] out_node_q;
  logic [DATA_WIDTH-1:0] out_score_q;

  // Sorted list, slot 0 holds the largest score.
  logic                  slot_v_q [0:TOPK-1];
  logic [DATA_WIDTH-1:0] slot_s_q [0:TOPK-1];
  logic [ADDR_WIDTH-1:0] slot_n_q [0:TOPK-1];

  logic                  slot_v_d [0:TOPK-1];
  logic [DATA_WIDTH-1:0] slot_s_d [0:TOPK-1];
  logic [ADDR_WIDTH-1:0] slot_n_d [0:TOPK-1];
  logic                  beats    [0:TOPK-1];

  logic          accept_start;
  logic          beat_hs;
  logic [EW-1:0] e_nxt;

  assign beat_hs = out_valid_q && res.out_ready;
  assign e_nxt   = e_q + EW'(1);

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SCAN;
          accept_start = 1'b1;
        end
      end
      SCAN: begin
        if (cnt_q == LAST_ADDR) state_d = FLUSH;
      end
      FLUSH: begin
        state_d = EMIT;
      end
      EMIT: begin
        if (beat_hs && (e_q == LAST_E)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The read address is the scan counter itself; the counter stops on the
  // last address, so mem_addr holds once reading ends.
  assign mem_rd_en = (state_q == SCAN);
  assign mem_addr  = cnt_q;
  assign dbg_state = state_q;
  assign busy      = busy_q;
  assign done      = done_q;

  assign res.out_valid = out_valid_q;
  assign res.out_last  = out_last_q;
  assign res.out_node  = out_node_q;
  assign res.out_score = out_score_q;

  // ---------------------------------------------------------------------------
  // Parallel sorted insertion of the returning sample.
  // A strict compare keeps an earlier node ahead of a later one on a tie.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < TOPK; i++) begin
      beats[i] = !slot_v_q[i] || (mem_data_in > slot_s_q[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < TOPK; i++) begin
      slot_v_d[i] = slot_v_q[i];
      slot_s_d[i] = slot_s_q[i];
      slot_n_d[i] = slot_n_q[i];
    end
    if (beats[0]) begin
      slot_v_d[0] = 1'b1;
      slot_s_d[0] = mem_data_in;
      slot_n_d[0] = rd_node_q;
    end
    // A slot either shifts down from its upper neighbour (the new sample
    // landed above it), takes the new sample, or keeps its entry.
    for (int i = 1; i < TOPK; i++) begin
      if (beats[i-1]) begin
        slot_v_d[i] = slot_v_q[i-1];
        slot_s_d[i] = slot_s_q[i-1];
        slot_n_d[i] = slot_n_q[i-1];
      end else if (beats[i]) begin
        slot_v_d[i] = 1'b1;
        slot_s_d[i] = mem_data_in;
        slot_n_d[i] = rd_node_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      e_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_node_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_node_q  <= '0;
      out_score_q <= '0;
      for (int i = 0; i < TOPK; i++) begin
        slot_v_q[i] <= 1'b0;
        slot_s_q[i] <= '0;
        slot_n_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      done_q    <= 1'b0;
      rd_pend_q <= mem_rd_en;
      rd_node_q <= mem_addr;

      if (accept_start) begin
        cnt_q  <= '0;
        busy_q <= 1'b1;
        for (int i = 0; i < TOPK; i++) slot_v_q[i] <= 1'b0;
      end else if (rd_pend_q) begin
        for (int i = 0; i < TOPK; i++) begin
          slot_v_q[i] <= slot_v_d[i];
          slot_s_q[i] <= slot_s_d[i];
          slot_n_q[i] <= slot_n_d[i];
        end
      end

      if ((state_q == SCAN) && (cnt_q != LAST_ADDR)) cnt_q <= cnt_q + ADDR_WIDTH'(1);

      if (state_q == FLUSH) e_q <= '0;

      if (state_q == EMIT) begin
        if (!out_valid_q) begin
          // First EMIT cycle: the list is final, present slot 0.
          out_valid_q <= 1'b1;
          out_node_q  <= slot_n_q[e_q];
          out_score_q <= slot_s_q[e_q];
          out_last_q  <= (e_q == LAST_E);
        end else if (beat_hs) begin
          if (e_q == LAST_E) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_node_q  <= '0;
            out_score_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            e_q         <= e_nxt;
            out_node_q  <= slot_n_q[e_nxt];
            out_score_q <= slot_s_q[e_nxt];
            out_last_q  <= (e_nxt == LAST_E);
          end
        end
      end
    end
  end

endmodule
